fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_queue.sv | 82 ++++++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU front-end package.
// Holds the default fetch geometry and the fetch-bundle layout used by the front end. It also
// provides a helper that gives the packed bundle width for any address/data width pair.
package fetch_unit_pkg;

  // Default instruction-memory word-address width.
  localparam int unsigned AddrWDefault  = 10;
  // Default instruction width.
  localparam int unsigned DataWDefault  = 32;
  // Default fetch-queue depth in bundles; must be a power of two.
  localparam int unsigned QDepthDefault = 4;

  // Two-wide fetch bundle at the default geometry.
  // pc1/instr1 are the older slot. pc2 is always pc1+1, wrapping at the address width.
  typedef struct packed {
    logic [AddrWDefault-1:0] pc1;
    logic [AddrWDefault-1:0] pc2;
    logic [DataWDefault-1:0] instr1;
    logic [DataWDefault-1:0] instr2;
  } fetch_bundle_t;

  // Packed width of a bundle for an arbitrary geometry.
  function automatic int unsigned bundle_width(input int unsigned addr_w,
                                               input int unsigned data_w);
    return 2 * addr_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO that holds fetched bundles between the ROM and decode.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   push/wdata : write one entry at the tail
//   pop        : retire the head entry; ignored while the queue is empty
//   flush      : empty the queue; overrides push and pop in the same cycle
//   rdata      : head entry; don't-care while empty
//   count      : number of valid entries, 0..Depth
//   empty      : count == 0
// Depth must be a power of two so that the pointers wrap naturally.
module fetch_queue #(
  parameter int unsigned Width = 84,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             empty
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PtrW'(1);
      if (do_pop)  head_d = head_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // The storage needs no reset; the valid range is defined by the pointers and the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= wdata;
  end

  assign rdata = mem_q[head_q];
  assign count = count_q;

  // The credit rule in the producer must never let a push arrive at a full queue.
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n) push && !flush |-> !full);

endmodule

// File: rtl/fetch_unit.sv
// Two-wide instruction fetch unit.
// It drives a dual-port synchronous ROM with a pair of consecutive word addresses. The returned
// instruction pair is packed into a bundle and queued for decode.
// Ports:
//   clk, rst_n             : clock and asynchronous active-low reset
//   rom_addr1/rom_addr2    : slot addresses f_pc and f_pc+1, driven from the PC register
//   rom_instr1/rom_instr2  : ROM data, valid one edge after the address is sampled
//   redirect/redirect_pc   : redirect strobe and target; flushes all fetched state
//   if_valid/id_ready      : decode handshake on the head bundle
//   if_pc*/if_instr*       : head bundle contents
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned QDEPTH = QDepthDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr1,
  output logic [ADDR_W-1:0] rom_addr2,
  input  logic [DATA_W-1:0] rom_instr1,
  input  logic [DATA_W-1:0] rom_instr2,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] if_pc1,
  output logic [ADDR_W-1:0] if_pc2,
  output logic [DATA_W-1:0] if_instr1,
  output logic [DATA_W-1:0] if_instr2
);

  localparam int unsigned CntW    = $clog2(QDEPTH + 1);
  localparam int unsigned CreditW = CntW + 1;
  localparam int unsigned EntryW  = bundle_width(ADDR_W, DATA_W);

  typedef struct packed {
    logic [ADDR_W-1:0] pc1;
    logic [ADDR_W-1:0] pc2;
    logic [DATA_W-1:0] instr1;
    logic [DATA_W-1:0] instr2;
  } bundle_t;

  logic [ADDR_W-1:0]  f_pc_q;
  logic [ADDR_W-1:0]  inflight_pc_q;
  logic               inflight_valid_q;
  logic [CntW-1:0]    q_count;
  logic               q_empty;
  logic [CreditW-1:0] credit_used;
  logic               req;
  logic               push;
  logic               pop;
  bundle_t            push_bundle;
  bundle_t            head_bundle;

  // Queued entries plus the one in flight must leave room for the bundle being requested.
  // That bundle lands in the queue one edge after it is requested.
  assign credit_used = {1'b0, q_count} + CreditW'(inflight_valid_q);
  assign req         = !redirect && (credit_used < CreditW'(QDEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pc_q           <= '0;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
    end else begin
      inflight_valid_q <= req;
      if (redirect) begin
        f_pc_q <= redirect_pc;
      end else if (req) begin
        f_pc_q        <= f_pc_q + ADDR_W'(2);
        inflight_pc_q <= f_pc_q;
      end
    end
  end

  assign rom_addr1 = f_pc_q;
  assign rom_addr2 = f_pc_q + ADDR_W'(1);

  // ROM data for the in-flight request is on the bus now.
  // A redirect in this cycle discards it.
  assign push = inflight_valid_q && !redirect;
  assign pop  = if_valid && id_ready;

  always_comb begin
    push_bundle        = '0;
    push_bundle.pc1    = inflight_pc_q;
    push_bundle.pc2    = inflight_pc_q + ADDR_W'(1);
    push_bundle.instr1 = rom_instr1;
    push_bundle.instr2 = rom_instr2;
  end

  fetch_queue #(
    .Width(EntryW),
    .Depth(QDEPTH)
  ) u_fetch_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(redirect),
    .wdata(push_bundle),
    .rdata(head_bundle),
    .count(q_count),
    .empty(q_empty)
  );

  // Masking with redirect keeps bundles from the old path from reaching decode.
  // The flush itself only takes effect on the edge.
  assign if_valid  = !q_empty && !redirect;
  assign if_pc1    = head_bundle.pc1;
  assign if_pc2    = head_bundle.pc2;
  assign if_instr1 = head_bundle.instr1;
  assign if_instr2 = head_bundle.instr2;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned QD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rom_addr1, rom_addr2;
  logic [DW-1:0] rom_instr1, rom_instr2;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          if_valid;
  logic          id_ready;
  logic [AW-1:0] if_pc1, if_pc2;
  logic [DW-1:0] if_instr1, if_instr2;
  fetch_bundle_t obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .QDEPTH(QD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rom_addr1  (rom_addr1),
    .rom_addr2  (rom_addr2),
    .rom_instr1 (rom_instr1),
    .rom_instr2 (rom_instr2),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .id_ready   (id_ready),
    .if_pc1     (if_pc1),
    .if_pc2     (if_pc2),
    .if_instr1  (if_instr1),
    .if_instr2  (if_instr2)
  );

  // ROM model: word[a] = A000_0000 + a, one-cycle synchronous read.
  always @(posedge clk) begin
    rom_instr1 <= 32'hA000_0000 + {22'd0, rom_addr1};
    rom_instr2 <= 32'hA000_0000 + {22'd0, rom_addr2};
  end

  assign obs = '{pc1: if_pc1, pc2: if_pc2, instr1: if_instr1, instr2: if_instr2};

  function automatic fetch_bundle_t mk(input logic [AW-1:0] pc);
    fetch_bundle_t b;
    b.pc1    = pc;
    b.pc2    = pc + 10'd1;
    b.instr1 = 32'hA000_0000 + {22'd0, b.pc1};
    b.instr2 = 32'hA000_0000 + {22'd0, b.pc2};
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 10'h055;
    id_ready    = 1'b1;
    repeat (3) step();
    checks++;
    if (if_valid !== 1'b0 || rom_addr1 !== 10'd0 || rom_addr2 !== 10'd1 || dut.q_count !== 3'd0)
    begin
      errors++;
      $display("FAIL reset: valid=%b a1=%h a2=%h cnt=%0d, want 0 000 001 0",
               if_valid, rom_addr1, rom_addr2, dut.q_count);
    end
    redirect = 1'b0;
  endtask

  task automatic test_stream();
    id_ready = 1'b1;
    rst_n    = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b0 || rom_addr1 !== 10'd2) begin
      errors++;
      $display("FAIL first_req: valid=%b a1=%h, want 0 002", if_valid, rom_addr1);
    end
    step();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (if_valid !== 1'b1 || obs !== mk(10'(2 * k))) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b got=%h want=%h", k, if_valid, obs, mk(10'(2 * k)));
      end
      step();
    end
    checks++;
    if (dut.q_count !== 3'd1) begin
      errors++;
      $display("FAIL steady_count: got %0d want 1", dut.q_count);
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    do_reset();
    repeat (12) step();
    checks++;
    if (dut.q_count !== 3'd4 || rom_addr1 !== 10'd8 || if_valid !== 1'b1 || obs !== mk(10'd0))
    begin
      errors++;
      $display("FAIL stall: cnt=%0d a1=%h valid=%b head=%h, want 4 008 1 %h",
               dut.q_count, rom_addr1, if_valid, obs, mk(10'd0));
    end
    id_ready = 1'b1;
    checks++;
    if (if_valid !== 1'b1 || obs !== mk(10'd0)) begin
      errors++;
      $display("FAIL release_head: valid=%b got=%h want=%h", if_valid, obs, mk(10'd0));
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || obs !== mk(10'(2 * k))) begin
        errors++;
        $display("FAIL resume[%0d]: valid=%b got=%h want=%h", k, if_valid, obs, mk(10'(2 * k)));
      end
    end
  endtask

  task automatic test_redirect_full();
    id_ready = 1'b0;
    repeat (6) step();
    checks++;
    if (dut.q_count !== 3'd4) begin
      errors++;
      $display("FAIL prefill: cnt=%0d want 4", dut.q_count);
    end
    redirect    = 1'b1;
    redirect_pc = 10'h101;
    id_ready    = 1'b1;
    #1;
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_mask: valid=%b want 0", if_valid);
    end
    step();
    redirect = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || rom_addr1 !== 10'h101 || dut.q_count !== 3'd0) begin
      errors++;
      $display("FAIL redir_c1: valid=%b a1=%h cnt=%0d, want 0 101 0",
               if_valid, rom_addr1, dut.q_count);
    end
    step();
    checks++;
    if (if_valid !== 1'b0 || rom_addr1 !== 10'h103) begin
      errors++;
      $display("FAIL redir_c2: valid=%b a1=%h, want 0 103", if_valid, rom_addr1);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || obs !== mk(10'(10'h101 + 2 * k))) begin
        errors++;
        $display("FAIL odd[%0d]: valid=%b got=%h want=%h",
                 k, if_valid, obs, mk(10'(10'h101 + 2 * k)));
      end
    end
  endtask

  task automatic test_wrap();
    redirect    = 1'b1;
    redirect_pc = 10'h3FF;
    step();
    redirect = 1'b0;
    checks++;
    if (rom_addr1 !== 10'h3FF || rom_addr2 !== 10'h000) begin
      errors++;
      $display("FAIL wrap_addr: a1=%h a2=%h want 3ff 000", rom_addr1, rom_addr2);
    end
    step();
    checks++;
    if (if_valid !== 1'b0 || rom_addr1 !== 10'h001) begin
      errors++;
      $display("FAIL wrap_next: valid=%b a1=%h want 0 001", if_valid, rom_addr1);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || obs !== mk(10'h3FF)) begin
      errors++;
      $display("FAIL wrap_b0: valid=%b got=%h want=%h", if_valid, obs, mk(10'h3FF));
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || obs !== mk(10'h001)) begin
      errors++;
      $display("FAIL wrap_b1: valid=%b got=%h want=%h", if_valid, obs, mk(10'h001));
    end
  endtask

  task automatic test_redirect_collide();
    repeat (2) step();
    // Back-to-back redirects while push and pop are both active; only the last target survives.
    redirect    = 1'b1;
    redirect_pc = 10'h200;
    #1;
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_mask0: valid=%b want 0", if_valid);
    end
    step();
    redirect_pc = 10'h300;
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_mask1: valid=%b want 0", if_valid);
    end
    step();
    redirect = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (if_valid !== 1'b0) begin
        errors++;
        $display("FAIL collide_gap[%0d]: valid=%b pc1=%h want valid 0", c, if_valid, if_pc1);
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (if_valid !== 1'b1 || obs !== mk(10'(10'h300 + 2 * k))) begin
        errors++;
        $display("FAIL collide[%0d]: valid=%b got=%h want=%h",
                 k, if_valid, obs, mk(10'(10'h300 + 2 * k)));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b0;
    step();
    step();
    checks++;
    if (dut.q_count !== 3'd3) begin
      errors++;
      $display("FAIL mid_depth: cnt=%0d want 3", dut.q_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || rom_addr1 !== 10'd0 || rom_addr2 !== 10'd1 || dut.q_count !== 3'd0)
    begin
      errors++;
      $display("FAIL async_reset: valid=%b a1=%h a2=%h cnt=%0d, want 0 000 001 0",
               if_valid, rom_addr1, rom_addr2, dut.q_count);
    end
    id_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b0 || rom_addr1 !== 10'd2) begin
      errors++;
      $display("FAIL restart_req: valid=%b a1=%h want 0 002", if_valid, rom_addr1);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || obs !== mk(10'(2 * k))) begin
        errors++;
        $display("FAIL restart[%0d]: valid=%b got=%h want=%h", k, if_valid, obs, mk(10'(2 * k)));
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_wrap();
    test_redirect_collide();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
